sensor_responder: RTL

Sensor-side endpoint of the polled sensor link, directly upstream of the bus arbitrator. Receives a one-byte poll from a byte-level UART and, when addressed, samples its local sensor value, computes a bit-serial CRC-8 and transmits a two-byte frame (data, CRC) back through the UART. A latched alarm replaces the data frame with an alarm frame until the arbitrator issues a broadcast recovery poll.

---
 rtl/sensor_link_pkg.sv | 27 ++
 rtl/crc8_serial.sv | 38 +++
 rtl/sensor_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sensor_link_pkg.sv
// Shared definitions for the polled sensor link, used by both the sensor
// responder and the bus arbitrator: FSM state encoding, CRC-8 constants,
// broadcast address and the default alarm byte.
package sensor_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CRC_CALC  = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_SEND_CRC  = 3'd4,
        ST_WAIT_CRC  = 3'd5
    } link_state_e;

    localparam logic [7:0] CRC8_POLY          = 8'h07;
    localparam logic [2:0] BROADCAST_ADDR     = 3'd0;
    localparam logic [7:0] DEFAULT_ALARM_CODE = 8'hFF;

    // One MSB-first CRC-8 step: shift the register left and fold in the
    // polynomial whenever the outgoing bit differs from the incoming data bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no
// final XOR). start clears the register; enable folds in one bit per cycle.
module crc8_serial
    import sensor_link_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: clear on start, otherwise advance one bit when enabled.
    always_comb begin
        crc_d = crc_q;
        if (start) begin
            crc_d = 8'h00;
        end else if (enable) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    // CRC register with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sensor_responder.sv
// Sensor-side endpoint of the polled sensor link. Accepts a one-byte poll
// from the UART receiver, and when addressed answers with a two-byte frame
// (sensor data, CRC-8). Optional alarm latch guarded by the macro
// SENSOR_RESPONDER_ALARM_EN: when defined, a latched alarm turns every reply
// into ALARM_CODE/ALARM_CODE until a broadcast poll clears it.
//
// Handshakes: rx_rdy is a level from the UART; a byte is consumed by a
// single-cycle rx_rdy_clr pulse, and a poll is only accepted in IDLE when no
// acknowledge is already outstanding (rx_rdy may still be high the cycle after
// rx_rdy_clr). tx_wr_en is a single-cycle start pulse issued only while
// tx_busy is low; tx_data is held until the transmitter has raised and then
// dropped tx_busy.
module sensor_responder
    import sensor_link_pkg::*;
#(
    parameter logic [2:0] SENSOR_ID  = 3'd1,
    parameter logic [7:0] ALARM_CODE = DEFAULT_ALARM_CODE
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_rdy_clr,
    output logic [7:0] tx_data,
    output logic       tx_wr_en,
    input  logic       tx_busy,
    input  logic [7:0] sensor_data,
    input  logic       alarm_in,
    output logic       busy,
    output logic       alarm_pending
);

    link_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        seen_busy_q, seen_busy_d;
    logic        alarm_frame_q, alarm_frame_d;
    logic        alarm_pending_q, alarm_pending_d;
    logic        rx_rdy_clr_q, rx_rdy_clr_d;
    logic        tx_wr_en_q, tx_wr_en_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        crc_start;
    logic        crc_en;
    logic        crc_bit;
    logic [7:0]  crc_value;
    logic        poll_valid;
    logic        bcast_clr;

    crc8_serial u_crc (
        .clock  (clock),
        .resetn (resetn),
        .start  (crc_start),
        .enable (crc_en),
        .bit_in (crc_bit),
        .crc    (crc_value)
    );

    // A fresh poll is one not already acknowledged in the previous cycle.
    assign poll_valid = rx_rdy && !rx_rdy_clr_q;

    // Next-state and registered-output logic for the response sequencer.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        bit_cnt_d     = bit_cnt_q;
        seen_busy_d   = seen_busy_q;
        alarm_frame_d = alarm_frame_q;
        tx_data_d     = tx_data_q;
        rx_rdy_clr_d  = 1'b0;
        tx_wr_en_d    = 1'b0;
        crc_start     = 1'b0;
        crc_en        = 1'b0;
        crc_bit       = data_q[~bit_cnt_q];
        bcast_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (poll_valid) begin
                    rx_rdy_clr_d = 1'b1;
                    if (rx_data[2:0] == SENSOR_ID) begin
                        data_d        = alarm_pending_q ? ALARM_CODE : sensor_data;
                        alarm_frame_d = alarm_pending_q;
                        bit_cnt_d     = 3'd0;
                        crc_start     = 1'b1;
                        state_d       = ST_CRC_CALC;
                    end else if (rx_data[2:0] == BROADCAST_ADDR) begin
                        bcast_clr = 1'b1;
                    end
                end
            end
            ST_CRC_CALC: begin
                crc_en    = 1'b1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (!tx_busy) begin
                    tx_wr_en_d  = 1'b1;
                    tx_data_d   = data_q;
                    seen_busy_d = 1'b0;
                    state_d     = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = ST_SEND_CRC;
                end
            end
            ST_SEND_CRC: begin
                if (!tx_busy) begin
                    tx_wr_en_d  = 1'b1;
                    tx_data_d   = alarm_frame_q ? ALARM_CODE : crc_value;
                    seen_busy_d = 1'b0;
                    state_d     = ST_WAIT_CRC;
                end
            end
            ST_WAIT_CRC: begin
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SENSOR_RESPONDER_ALARM_EN
        // Alarm request wins over a broadcast clear in the same cycle.
        alarm_pending_d = alarm_in | (alarm_pending_q & ~bcast_clr);
`else
        // Alarm path disabled: the latch stays clear whatever arrives.
        alarm_pending_d = 1'b0 & (alarm_in | bcast_clr);
`endif
    end

    // All sequencer state and outputs, cleared asynchronously on reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            data_q          <= 8'h00;
            bit_cnt_q       <= 3'd0;
            seen_busy_q     <= 1'b0;
            alarm_frame_q   <= 1'b0;
            alarm_pending_q <= 1'b0;
            rx_rdy_clr_q    <= 1'b0;
            tx_wr_en_q      <= 1'b0;
            tx_data_q       <= 8'h00;
        end else begin
            state_q         <= state_d;
            data_q          <= data_d;
            bit_cnt_q       <= bit_cnt_d;
            seen_busy_q     <= seen_busy_d;
            alarm_frame_q   <= alarm_frame_d;
            alarm_pending_q <= alarm_pending_d;
            rx_rdy_clr_q    <= rx_rdy_clr_d;
            tx_wr_en_q      <= tx_wr_en_d;
            tx_data_q       <= tx_data_d;
        end
    end

    assign rx_rdy_clr    = rx_rdy_clr_q;
    assign tx_wr_en      = tx_wr_en_q;
    assign tx_data       = tx_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign alarm_pending = alarm_pending_q;

endmodule
